// File: rtl/rom_pkg.sv
// Shared definitions for the instruction ROM and the blocks that read it.
package rom_pkg;

  localparam int ROM_DATA_W = 29;
  localparam int ROM_ADDR_W = 11;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/rom_port_arbiter_rr_arb2.sv
// Two-input picker: fixed CPU priority or alternate-on-conflict, one-hot grant.
// Bit 0 of req/gnt is the CPU and bit 1 is the debug port.
module rr_arb2
  import rom_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  owner_e last_owner;

  // Grant is purely a function of the requests and who won the last conflict.
  always_comb begin
    gnt = 2'b00;
    if (rst) begin
      gnt = 2'b00;
    end else if (req == 2'b11) begin
      if (FIXED_PRIO != 0 || last_owner == OWN_DBG) begin
        gnt = 2'b01;
      end else begin
        gnt = 2'b10;
      end
    end else begin
      gnt = req;
    end
  end

  // Remember the conflict winner only; a lone requester does not shift fairness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWN_DBG;
    end else if (req == 2'b11) begin
      last_owner <= gnt[0] ? OWN_CPU : OWN_DBG;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single ROM read port between CPU fetch and debug readback.
// Stage 1 registers the winning address, stage 2 registers the ROM word
// into the owner's data register and pulses that owner's valid.
module rom_port_arbiter
  import rom_pkg::*;
#(
  parameter int DATA_W     = ROM_DATA_W,
  parameter int ADDR_W     = ROM_ADDR_W,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  input  logic              cpu_flush,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_data,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_valid,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  logic [1:0] gnt;
  logic       s1_vld;
  owner_e     s1_own;
  logic       cpu_take;
  logic       dbg_take;

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk(clk),
    .rst(rst),
    .req({dbg_req, cpu_req}),
    .gnt(gnt)
  );

  assign cpu_gnt = gnt[0];
  assign dbg_gnt = gnt[1];

  // A flush kills the CPU read leaving stage 1 at this edge; a CPU grant made
  // at the same edge is newer than the flush and goes ahead untouched.
  assign cpu_take = s1_vld && (s1_own == OWN_CPU) && !cpu_flush;
  assign dbg_take = s1_vld && (s1_own == OWN_DBG);

  // Stage 1: capture the winner's address; the address holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      s1_vld   <= 1'b0;
      s1_own   <= OWN_CPU;
    end else begin
      s1_vld <= |gnt;
      if (gnt[0]) begin
        rom_addr <= cpu_addr;
        s1_own   <= OWN_CPU;
      end else if (gnt[1]) begin
        rom_addr <= dbg_addr;
        s1_own   <= OWN_DBG;
      end
    end
  end

  // Stage 2: register the ROM word for its owner; the other port keeps its data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_valid <= 1'b0;
      dbg_valid <= 1'b0;
      cpu_data  <= '0;
      dbg_data  <= '0;
    end else begin
      cpu_valid <= cpu_take;
      dbg_valid <= dbg_take;
      if (cpu_take) begin
        cpu_data <= rom_data;
      end
      if (dbg_take) begin
        dbg_data <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: one round-robin and one fixed-priority instance
// run side by side against a history-based model of grants and deliveries.
module tb_rom_port_arbiter;
  import rom_pkg::*;

  localparam int AW   = ROM_ADDR_W;
  localparam int DW   = ROM_DATA_W;
  localparam int NI   = 2;
  localparam int MAXC = 8000;

  logic clk = 1'b0;
  logic rst;

  logic          cpu_req   [NI];
  logic [AW-1:0] cpu_addr  [NI];
  logic          cpu_gnt   [NI];
  logic          cpu_flush [NI];
  logic          cpu_valid [NI];
  logic [DW-1:0] cpu_data  [NI];
  logic          dbg_req   [NI];
  logic [AW-1:0] dbg_addr  [NI];
  logic          dbg_gnt   [NI];
  logic          dbg_valid [NI];
  logic [DW-1:0] dbg_data  [NI];
  logic [AW-1:0] rom_addr  [NI];
  logic [DW-1:0] rom_data  [NI];

  logic [DW-1:0] rom [2**AW];

  int n_vec;
  int n_err;
  int edge_n;

  // Grant history per instance: valid, owner (1 = debug), address
  bit            h_gv [NI][MAXC];
  bit            h_go [NI][MAXC];
  logic [AW-1:0] h_ga [NI][MAXC];

  bit            m_last [NI];
  bit            m_cv   [NI];
  bit            m_dv   [NI];
  logic [DW-1:0] m_cd   [NI];
  logic [DW-1:0] m_dd   [NI];
  logic [AW-1:0] m_ra   [NI];

  logic [DW-1:0] t2_exp [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    rom_port_arbiter #(
      .DATA_W(DW),
      .ADDR_W(AW),
      .FIXED_PRIO(g)
    ) dut (
      .clk(clk),
      .rst(rst),
      .cpu_req(cpu_req[g]),
      .cpu_addr(cpu_addr[g]),
      .cpu_gnt(cpu_gnt[g]),
      .cpu_flush(cpu_flush[g]),
      .cpu_valid(cpu_valid[g]),
      .cpu_data(cpu_data[g]),
      .dbg_req(dbg_req[g]),
      .dbg_addr(dbg_addr[g]),
      .dbg_gnt(dbg_gnt[g]),
      .dbg_valid(dbg_valid[g]),
      .dbg_data(dbg_data[g]),
      .rom_addr(rom_addr[g]),
      .rom_data(rom_data[g])
    );
    assign rom_data[g] = rom[rom_addr[g]];
  end

  task automatic initRom();
    for (int a = 0; a < 2**AW; a++) begin
      rom[a] = DW'((a * 32'h9E3779B1) ^ 32'h05A5A5A5);
    end
    rom[0] = 29'h01f040ff;
    rom[1] = 29'h01000020;
    rom[2] = 29'h15000005;
    rom[3] = 29'h01000045;
    rom[5] = 29'h16e00000;
    rom[6] = 29'h03ee0005;
    rom[8] = 29'h03ff0001;
    t2_exp[0] = 29'h01f040ff;
    t2_exp[1] = 29'h01000020;
    t2_exp[2] = 29'h15000005;
    t2_exp[3] = 29'h01000045;
  endtask

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s inst%0d @edge %0d: got %h, expected %h", name, i, edge_n, act, exp);
    end
  endtask

  task automatic modelResetInst(int i);
    m_last[i] = 1'b1;
    m_cv[i]   = 1'b0;
    m_dv[i]   = 1'b0;
    m_cd[i]   = '0;
    m_dd[i]   = '0;
    m_ra[i]   = '0;
  endtask

  task automatic modelReset();
    for (int i = 0; i < NI; i++) modelResetInst(i);
  endtask

  // Expected one-hot grant {dbg, cpu}; instance 1 is the fixed-priority one
  function automatic logic [1:0] expGnt(int i);
    if (rst) return 2'b00;
    if (cpu_req[i] && dbg_req[i]) return (i == 1 || m_last[i]) ? 2'b01 : 2'b10;
    return {dbg_req[i], cpu_req[i]};
  endfunction

  // Advance the model by one rising edge using the inputs held across it
  task automatic modelEdge();
    int e;
    e = edge_n;
    for (int i = 0; i < NI; i++) begin
      logic [1:0] g;
      if (rst) begin
        modelResetInst(i);
        h_gv[i][e] = 1'b0;
      end else begin
        g = expGnt(i);
        m_cv[i] = 1'b0;
        m_dv[i] = 1'b0;
        if (e > 0 && h_gv[i][e-1]) begin
          if (!h_go[i][e-1]) begin
            if (!cpu_flush[i]) begin
              m_cv[i] = 1'b1;
              m_cd[i] = rom[h_ga[i][e-1]];
            end
          end else begin
            m_dv[i] = 1'b1;
            m_dd[i] = rom[h_ga[i][e-1]];
          end
        end
        h_gv[i][e] = (g != 2'b00);
        h_go[i][e] = g[1];
        h_ga[i][e] = g[1] ? dbg_addr[i] : cpu_addr[i];
        if (g != 2'b00) m_ra[i] = h_ga[i][e];
        if (cpu_req[i] && dbg_req[i]) m_last[i] = g[1];
      end
    end
  endtask

  task automatic checkGnt();
    for (int i = 0; i < NI; i++) begin
      logic [1:0] g;
      g = expGnt(i);
      chk("cpu_gnt", i, 32'(cpu_gnt[i]), 32'(g[0]));
      chk("dbg_gnt", i, 32'(dbg_gnt[i]), 32'(g[1]));
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < NI; i++) begin
      chk("cpu_valid", i, 32'(cpu_valid[i]), 32'(m_cv[i]));
      chk("dbg_valid", i, 32'(dbg_valid[i]), 32'(m_dv[i]));
      chk("cpu_data",  i, 32'(cpu_data[i]),  32'(m_cd[i]));
      chk("dbg_data",  i, 32'(dbg_data[i]),  32'(m_dd[i]));
      chk("rom_addr",  i, 32'(rom_addr[i]),  32'(m_ra[i]));
    end
  endtask

  // Inputs are set at the falling edge; check gnt, take the rising edge, check outputs
  task automatic stepCycle();
    #1;
    checkGnt();
    @(posedge clk);
    modelEdge();
    edge_n++;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic setAll(bit cr, int ca, bit dr, int da, bit fl);
    for (int i = 0; i < NI; i++) begin
      cpu_req[i]   = cr;
      cpu_addr[i]  = AW'(ca);
      dbg_req[i]   = dr;
      dbg_addr[i]  = AW'(da);
      cpu_flush[i] = fl;
    end
  endtask

  function automatic logic [AW-1:0] pickAddr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 2**AW - 1));
    return AW'($urandom_range(0, 15));
  endfunction

  // Random requesters: hold req/addr until granted, then drop or re-request
  task automatic applyStimulus();
    for (int i = 0; i < NI; i++) begin
      bit got_c;
      bit got_d;
      got_c = (edge_n > 0) && h_gv[i][edge_n-1] && !h_go[i][edge_n-1];
      got_d = (edge_n > 0) && h_gv[i][edge_n-1] &&  h_go[i][edge_n-1];
      if (!cpu_req[i] || got_c) begin
        cpu_req[i]  = ($urandom_range(0, 9) < 6);
        cpu_addr[i] = pickAddr();
      end
      if (!dbg_req[i] || got_d) begin
        dbg_req[i]  = ($urandom_range(0, 9) < 5);
        dbg_addr[i] = pickAddr();
      end
      cpu_flush[i] = ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    edge_n = 0;
    rst    = 1'b1;
    setAll(0, 0, 0, 0, 0);
    modelReset();
    initRom();

    // Reset state
    repeat (2) stepCycle();
    for (int i = 0; i < NI; i++) begin
      chk("lit_rst_rom_addr",  i, 32'(rom_addr[i]),  32'h0);
      chk("lit_rst_cpu_valid", i, 32'(cpu_valid[i]), 32'h0);
      chk("lit_rst_cpu_data",  i, 32'(cpu_data[i]),  32'h0);
      chk("lit_rst_dbg_data",  i, 32'(dbg_data[i]),  32'h0);
    end
    rst = 1'b0;
    stepCycle();

    // Single CPU read of address 0
    setAll(1, 0, 0, 0, 0);
    #1;
    chk("lit_t1_cpu_gnt", 0, 32'(cpu_gnt[0]), 32'h1);
    stepCycle();
    setAll(0, 0, 0, 0, 0);
    stepCycle();
    chk("lit_t1_cpu_valid", 0, 32'(cpu_valid[0]), 32'h1);
    chk("lit_t1_cpu_data",  0, 32'(cpu_data[0]),  32'h01f040ff);
    chk("lit_t1_dbg_valid", 0, 32'(dbg_valid[0]), 32'h0);
    stepCycle();
    chk("lit_t1_valid_once", 0, 32'(cpu_valid[0]), 32'h0);

    // CPU streaming addresses 0..3
    for (int k = 0; k < 4; k++) begin
      setAll(1, k, 0, 0, 0);
      stepCycle();
      if (k > 0) begin
        chk("lit_t2_valid", 0, 32'(cpu_valid[0]), 32'h1);
        chk("lit_t2_data",  0, 32'(cpu_data[0]),  32'(t2_exp[k-1]));
      end
    end
    setAll(0, 0, 0, 0, 0);
    stepCycle();
    chk("lit_t2_valid", 0, 32'(cpu_valid[0]), 32'h1);
    chk("lit_t2_data",  0, 32'(cpu_data[0]),  32'(t2_exp[3]));
    stepCycle();

    // Permanent conflict: alternation on inst0, CPU lock-out of debug on inst1
    setAll(1, 5, 1, 6, 0);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("lit_t3_rr_cpu_gnt",  0, 32'(cpu_gnt[0]), 32'((k % 2) == 0));
      chk("lit_t3_fix_dbg_gnt", 1, 32'(dbg_gnt[1]), 32'h0);
      stepCycle();
      if (k > 0) begin
        chk("lit_t3_rr_cpu_valid", 0, 32'(cpu_valid[0]), 32'(((k - 1) % 2) == 0));
        chk("lit_t3_rr_dbg_valid", 0, 32'(dbg_valid[0]), 32'(((k - 1) % 2) == 1));
        if (((k - 1) % 2) == 0) chk("lit_t3_rr_cpu_data", 0, 32'(cpu_data[0]), 32'h16e00000);
        else                    chk("lit_t3_rr_dbg_data", 0, 32'(dbg_data[0]), 32'h03ee0005);
        chk("lit_t3_fix_cpu_data", 1, 32'(cpu_data[1]), 32'h16e00000);
      end
    end
    setAll(0, 0, 0, 0, 0);
    repeat (2) stepCycle();

    // Flush on the edge after a grant, with a fresh grant at the same edge
    setAll(1, 7, 0, 0, 0);
    stepCycle();
    setAll(1, 8, 0, 0, 1);
    stepCycle();
    for (int i = 0; i < NI; i++) chk("lit_t4_flushed", i, 32'(cpu_valid[i]), 32'h0);
    setAll(0, 0, 0, 0, 0);
    stepCycle();
    for (int i = 0; i < NI; i++) begin
      chk("lit_t4_valid", i, 32'(cpu_valid[i]), 32'h1);
      chk("lit_t4_data",  i, 32'(cpu_data[i]),  32'h03ff0001);
    end
    stepCycle();

    // Asynchronous reset one cycle after a grant
    setAll(1, 9, 0, 0, 0);
    stepCycle();
    setAll(0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("lit_t5_rom_addr",  i, 32'(rom_addr[i]),  32'h0);
      chk("lit_t5_cpu_data",  i, 32'(cpu_data[i]),  32'h0);
      chk("lit_t5_dbg_data",  i, 32'(dbg_data[i]),  32'h0);
      chk("lit_t5_cpu_valid", i, 32'(cpu_valid[i]), 32'h0);
    end
    repeat (2) stepCycle();
    rst = 1'b0;
    repeat (3) begin
      stepCycle();
      for (int i = 0; i < NI; i++) chk("lit_t5_no_valid", i, 32'(cpu_valid[i]), 32'h0);
    end
    setAll(1, 1, 1, 2, 0);
    #1;
    chk("lit_t5_first_conflict_cpu", 0, 32'(cpu_gnt[0]), 32'h1);
    chk("lit_t5_first_conflict_dbg", 0, 32'(dbg_gnt[0]), 32'h0);
    stepCycle();
    setAll(0, 0, 0, 0, 0);
    repeat (2) stepCycle();

    // Randomized traffic against the model
    repeat (3000) begin
      applyStimulus();
      stepCycle();
    end
    setAll(0, 0, 0, 0, 0);
    repeat (3) stepCycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Two-requester, pipelined arbiter sharing the single combinational read port of the 2048 x 29-bit instruction ROM between the CPU fetch stage and the debug/loader readback port. Each granted request registers its address into the ROM in the grant cycle and returns registered data to the owner two cycles later. Sustained throughput is one read per cycle. Sits between the fetch unit, the debug UART bridge, and the ROM instance.

## Interface
Parameters:
- DATA_W, 29, ROM word width
- ADDR_W, 11, ROM address width
- FIXED_PRIO, 0, 0 = round-robin on conflict; 1 = CPU always wins

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU read request, held until cpu_gnt sampled high
- cpu_addr  in  ADDR_W  CPU read address, stable while cpu_req high
- cpu_gnt  out  1  combinational grant; request accepted at this edge
- cpu_flush  in  1  discards all in-flight CPU reads
- cpu_valid  out  1  one-cycle pulse, cpu_data valid
- cpu_data  out  DATA_W  returned ROM word
- dbg_req / dbg_addr / dbg_gnt / dbg_valid / dbg_data: same as the CPU set, for the debug port (no flush)
- rom_addr  out  ADDR_W  registered address to ROM
- rom_data  in  DATA_W  combinational ROM read data

## Operation
- Grant logic is combinational:
  - One req high → that requester is granted.
  - Both high, FIXED_PRIO=1 → CPU granted.
  - Both high, FIXED_PRIO=0 → the requester not granted last time wins; last_owner updates only on a conflict grant.
- Stage 1, on the granting edge:
  - rom_addr <= winner addr
  - s1_vld <= 1
  - s1_own <= winner
  - With no grant, s1_vld <= 0 and rom_addr holds.
- Stage 2, next edge:
  - Captures rom_data into the owner's data register.
  - Sets the owner's valid for one cycle.
  - The other port's data register holds its value.
- cpu_flush high at an edge: clears s1_vld if s1_own=CPU, and suppresses a CPU valid set at that edge. Same-cycle cpu_gnt is still honoured (new fetch survives).
- A new grant is allowed every cycle. Stages never stall: requesters must accept valid when it pulses.
- Reset values:
  - rom_addr=0, cpu_data=0, dbg_data=0
  - cpu_valid=0, dbg_valid=0, s1_vld=0
  - last_owner=DBG, so the CPU wins the first conflict.
- Reset mid-operation drops all in-flight reads. No valid pulse follows reset release without a new grant.

## Timing
- Request sampled at edge N with gnt high → rom_addr valid during cycle N+1 → data captured at edge N+1 → valid high and data stable during cycle N+2. Latency is 2 edges.
- Back-to-back alternating grants: valids pulse on consecutive cycles in grant order.
- The requester drops or changes req/addr only after an edge where gnt was high. If req stays high, a new request is granted at a later edge.
- gnt depends only on the req inputs and last_owner. There is no combinational path from rom_data to any output.

## Structure
- Shared package rom_pkg: ROM_DATA_W=29, ROM_ADDR_W=11, and owner enum {OWN_CPU=0, OWN_DBG=1}. The ROM and this block both use it.
- Sub-module rr_arb2: 2-input round-robin/fixed-priority picker holding last_owner; outputs a one-hot grant.
- Top level: the pipeline registers and the flush logic.

## Test plan
- Reset, then CPU-only req, addr=0x000 → cpu_gnt same cycle; cpu_valid pulses 2 edges later with cpu_data=0x01f040ff; dbg_valid stays 0.
- CPU streams addrs 0..3 on consecutive cycles → four consecutive cpu_valid pulses with 0x01f040ff, 0x01000020, 0x15000005, 0x01000045.
- Both req every cycle, FIXED_PRIO=0, cpu_addr=5, dbg_addr=6 → grants alternate CPU, DBG, CPU…; cpu_data=0x16e00000, dbg_data=0x03ee0005. With FIXED_PRIO=1, dbg is never granted while cpu_req is high.
- CPU granted addr=7, cpu_flush high on the next edge together with a new CPU grant at addr=8 → no valid for addr 7; next cpu_valid carries 0x03ff0001.
- rst asserted asynchronously one cycle after a grant → all outputs 0 immediately; no valid after release; the first conflict after release goes to the CPU.
